// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - multi-channel active-low key debouncer with press/release/long-press pulses
// One free-running 1 ms prescaler is shared by every channel; each channel has its own synchroniser and FSM.
module key_debounce_array #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_KEYS      = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] Key_In,
  output logic [N_KEYS-1:0] Press_Pulse,
  output logic [N_KEYS-1:0] Release_Pulse,
  output logic [N_KEYS-1:0] Long_Pulse,
  output logic [N_KEYS-1:0] Key_State
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = $clog2(TICK_DIV);
  localparam int DW       = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int HW       = (LONG_MS > 1) ? $clog2(LONG_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic          r_sync1, r_sync2;
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_dcnt, w_dcnt_nxt;
    logic [HW-1:0] r_hcnt, w_hcnt_nxt;
    logic          r_long_done, w_long_done_nxt;
    logic          r_press, r_release, r_long, r_key_state;
    logic          w_press, w_release, w_long;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_sync1     <= 1'b1;
        r_sync2     <= 1'b1;
        r_state     <= ST_IDLE;
        r_dcnt      <= '0;
        r_hcnt      <= '0;
        r_long_done <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_key_state <= 1'b0;
      end else begin
        r_sync1     <= Key_In[g];
        r_sync2     <= r_sync1;
        r_state     <= w_state_nxt;
        r_dcnt      <= w_dcnt_nxt;
        r_hcnt      <= w_hcnt_nxt;
        r_long_done <= w_long_done_nxt;
        r_press     <= w_press;
        r_release   <= w_release;
        r_long      <= w_long;
        r_key_state <= w_press | (r_key_state & ~w_release);
      end
    end

    // A level change on the synchronised pin always wins over a tick in the same cycle.
    always_comb begin
      w_state_nxt     = r_state;
      w_dcnt_nxt      = r_dcnt;
      w_hcnt_nxt      = r_hcnt;
      w_long_done_nxt = r_long_done;
      w_press         = 1'b0;
      w_release       = 1'b0;
      w_long          = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            w_state_nxt = ST_PRESS_WAIT;
            w_dcnt_nxt  = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (r_sync2) begin
            w_state_nxt = ST_IDLE;
          end else if (w_tick) begin
            if (r_dcnt == DCNT_LAST) begin
              w_state_nxt     = ST_PRESSED;
              w_press         = 1'b1;
              w_hcnt_nxt      = '0;
              w_long_done_nxt = 1'b0;
            end else begin
              w_dcnt_nxt = r_dcnt + 1'b1;
            end
          end
        end
        ST_PRESSED: begin
          if (r_sync2) begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_dcnt_nxt  = '0;
          end else if (w_tick && !r_long_done) begin
            if (r_hcnt == HCNT_LAST) begin
              w_long          = 1'b1;
              w_long_done_nxt = 1'b1;
            end else begin
              w_hcnt_nxt = r_hcnt + 1'b1;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (!r_sync2) begin
            w_state_nxt = ST_PRESSED;
          end else if (w_tick) begin
            if (r_dcnt == DCNT_LAST) begin
              w_state_nxt = ST_IDLE;
              w_release   = 1'b1;
            end else begin
              w_dcnt_nxt = r_dcnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    assign Press_Pulse[g]   = r_press;
    assign Release_Pulse[g] = r_release;
    assign Long_Pulse[g]    = r_long;
    assign Key_State[g]     = r_key_state;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - self-checking bench for key_debounce_array
// Reference model tracks, per key, how long the synchronised pin has disagreed with the debounced level.
module tb_key_debounce_array;

  localparam int CLK_HZ = 10_000;
  localparam int N      = 4;
  localparam int DEB    = 3;
  localparam int LNG    = 8;
  localparam int TD     = CLK_HZ / 1000;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic [N-1:0] Key_In = '1;
  logic [N-1:0] Press_Pulse, Release_Pulse, Long_Pulse, Key_State;

  key_debounce_array #(
    .CLK_HZ(CLK_HZ), .N_KEYS(N), .DEBOUNCE_MS(DEB), .LONG_MS(LNG)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Key_In(Key_In),
    .Press_Pulse(Press_Pulse), .Release_Pulse(Release_Pulse),
    .Long_Pulse(Long_Pulse), .Key_State(Key_State)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [N-1:0]   pins = '1;
  logic [N-1:0]   e_press, e_rel, e_long, e_state;
  logic [4*N-1:0] exp_v;
  logic [N-1:0]   m_s1, m_s2;
  int             m_cyc;
  bit             m_lvl[N];
  bit             m_ld[N];
  int             m_age[N], m_dt[N], m_ht[N];

  wire [4*N-1:0] w_obs = {Press_Pulse, Release_Pulse, Long_Pulse, Key_State};

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_cyc = 0;
    e_press = '0; e_rel = '0; e_long = '0; e_state = '0; exp_v = '0;
    for (int k = 0; k < N; k++) begin
      m_lvl[k] = 0; m_ld[k] = 0; m_age[k] = 0; m_dt[k] = 0; m_ht[k] = 0;
    end
  endtask

  // Events decided on one clock edge are what the outputs show right after it.
  task automatic model_step(input logic [N-1:0] p);
    bit tick;
    bit held;
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    e_press = '0; e_rel = '0; e_long = '0;
    for (int k = 0; k < N; k++) begin
      held = (m_s2[k] == 1'b0);
      if (held == m_lvl[k]) begin
        if (m_lvl[k] && m_age[k] == 0 && tick && !m_ld[k]) begin
          m_ht[k]++;
          if (m_ht[k] == LNG) begin
            e_long[k] = 1'b1;
            m_ld[k] = 1;
          end
        end
        m_age[k] = 0;
        m_dt[k] = 0;
      end else begin
        if (m_age[k] > 0 && tick) m_dt[k]++;
        m_age[k]++;
        if (m_dt[k] == DEB) begin
          m_lvl[k] = !m_lvl[k];
          m_age[k] = 0;
          m_dt[k] = 0;
          if (m_lvl[k]) begin
            e_press[k] = 1'b1;
            m_ht[k] = 0;
            m_ld[k] = 0;
          end else begin
            e_rel[k] = 1'b1;
          end
        end
      end
      e_state[k] = m_lvl[k];
    end
    m_s2 = m_s1;
    m_s1 = p;
    exp_v = {e_press, e_rel, e_long, e_state};
  endtask

  task automatic cycle(input logic [N-1:0] p);
    pins = p;
    Key_In = p;
    @(posedge CLK);
    model_step(p);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    Key_In = '1;
    pins = '1;
    repeat (3) @(negedge CLK);
    checks++;
    if (w_obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", w_obs, {4*N{1'b0}});
    end
    RSTn = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(pins);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] p;
    int lat, np;
    lat = -1; np = 0;
    repeat ($urandom_range(0, TD - 1)) cycle(pins);
    p = pins;
    p[0] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle(p);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
      if (Press_Pulse[0]) begin
        np++;
        if (lat < 0) lat = i;
      end
    end
    checks++;
    if (np !== 1) begin errors++; $display("FAIL clean_press_count: got %0d expected 1", np); end
    checks++;
    if (lat < 23 || lat > 32) begin errors++; $display("FAIL clean_press_latency: got %0d expected 23..32", lat); end
    checks++;
    if (Key_State[0] !== 1'b1) begin errors++; $display("FAIL clean_press_state: got %b expected 1", Key_State[0]); end
  endtask

  task automatic test_press_bounce();
    logic [N-1:0] p;
    int np, len;
    np = 0;
    for (int b = 0; b < 4; b++) begin
      len = (b == 0) ? 15 : $urandom_range(1, 20);
      p = pins;
      p[1] = 1'b0;
      for (int i = 0; i < len; i++) begin
        cycle(p);
        checks++;
        if (w_obs !== exp_v) begin
          errors++;
          $display("FAIL press_bounce low %0d/%0d: got %h expected %h", i, len, w_obs, exp_v);
        end
        if (Press_Pulse[1] || Key_State[1]) np++;
      end
      p[1] = 1'b1;
      for (int i = 0; i < 5 + $urandom_range(0, 30); i++) begin
        cycle(p);
        checks++;
        if (w_obs !== exp_v) begin
          errors++;
          $display("FAIL press_bounce high %0d: got %h expected %h", i, w_obs, exp_v);
        end
        if (Press_Pulse[1] || Key_State[1]) np++;
      end
    end
    checks++;
    if (np !== 0) begin errors++; $display("FAIL press_bounce_rejected: got %0d active cycles expected 0", np); end
  endtask

  task automatic test_release_bounce();
    logic [N-1:0] p;
    int nr, ndrop, lat;
    nr = 0; ndrop = 0; lat = -1;
    p = pins;
    for (int ph = 0; ph < 2; ph++) begin
      p[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
        cycle(p);
        checks++;
        if (w_obs !== exp_v) begin
          errors++;
          $display("FAIL release_bounce high %0d: got %h expected %h", i, w_obs, exp_v);
        end
        if (Release_Pulse[0]) nr++;
        if (!Key_State[0]) ndrop++;
      end
      p[0] = 1'b0;
      for (int i = 0; i < 30; i++) begin
        cycle(p);
        checks++;
        if (w_obs !== exp_v) begin
          errors++;
          $display("FAIL release_bounce low %0d: got %h expected %h", i, w_obs, exp_v);
        end
        if (Release_Pulse[0]) nr++;
        if (!Key_State[0]) ndrop++;
      end
    end
    checks++;
    if (nr !== 0 || ndrop !== 0) begin
      errors++;
      $display("FAIL release_bounce_rejected: got %0d pulses %0d drops expected 0 0", nr, ndrop);
    end
    p[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(p);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL release cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
      if (Release_Pulse[0]) begin
        nr++;
        if (lat < 0) lat = i;
      end
    end
    checks++;
    if (nr !== 1) begin errors++; $display("FAIL release_count: got %0d expected 1", nr); end
    checks++;
    if (lat < 23 || lat > 32) begin errors++; $display("FAIL release_latency: got %0d expected 23..32", lat); end
    checks++;
    if (Key_State[0] !== 1'b0) begin errors++; $display("FAIL release_state: got %b expected 0", Key_State[0]); end
  endtask

  task automatic test_long_press();
    logic [N-1:0] p;
    int tp, tl, np, nl;
    tp = -1; tl = -1; np = 0; nl = 0;
    repeat ($urandom_range(0, TD - 1)) cycle(pins);
    p = pins;
    p[2] = 1'b0;
    for (int i = 0; i < 150; i++) begin
      cycle(p);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL long_press cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
      if (Press_Pulse[2]) begin np++; tp = i; end
      if (Long_Pulse[2]) begin nl++; tl = i; end
    end
    checks++;
    if (np !== 1 || nl !== 1) begin
      errors++;
      $display("FAIL long_press_counts: got press=%0d long=%0d expected 1 1", np, nl);
    end
    checks++;
    if (tl - tp < 71 || tl - tp > 80) begin
      errors++;
      $display("FAIL long_press_delay: got %0d expected 71..80", tl - tp);
    end
    p[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(p);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL long_release cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    int nall, npart;
    nall = 0; npart = 0;
    for (int i = 0; i < 40; i++) cycle('1);
    for (int i = 0; i < 40; i++) begin
      cycle('0);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL simultaneous cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
      if (Press_Pulse == 4'b1111) nall++;
      else if (Press_Pulse != 4'b0000) npart++;
    end
    checks++;
    if (nall !== 1 || npart !== 0) begin
      errors++;
      $display("FAIL simultaneous_press: got all=%0d partial=%0d expected 1 0", nall, npart);
    end
    for (int i = 0; i < 40; i++) begin
      cycle('1);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL simultaneous_release cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] p;
    int lat, np;
    lat = -1; np = 0;
    p = 4'b1110;
    for (int i = 0; i < 40; i++) cycle(p);
    checks++;
    if (Key_State !== 4'b0001) begin errors++; $display("FAIL reset_mid_pre: got %b expected 0001", Key_State); end
    p[3] = 1'b0;
    for (int i = 0; i < 12; i++) cycle(p);
    RSTn = 1'b0;
    #1;
    checks++;
    if (w_obs !== '0) begin errors++; $display("FAIL reset_mid_async: got %h expected 0", w_obs); end
    repeat (3) @(negedge CLK);
    checks++;
    if (w_obs !== '0) begin errors++; $display("FAIL reset_mid_hold: got %h expected 0", w_obs); end
    RSTn = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(p);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_after cyc %0d: got %h expected %h", i, w_obs, exp_v);
      end
      if (Press_Pulse[3]) begin
        np++;
        if (lat < 0) lat = i;
      end
    end
    checks++;
    if (np !== 1 || lat < 23 || lat > 32) begin
      errors++;
      $display("FAIL reset_mid_repress: got count=%0d latency=%0d expected 1 in 23..32", np, lat);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    int run[N];
    p = pins;
    for (int k = 0; k < N; k++) run[k] = $urandom_range(1, 40);
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++) begin
        run[k]--;
        if (run[k] <= 0) begin
          p[k] = ~p[k];
          run[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 25) : $urandom_range(20, 120);
        end
      end
      cycle(p);
      checks++;
      if (w_obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d pins %b: got %h expected %h", i, p, w_obs, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
